// File: rtl/ckg_pkg.sv
// ---------------------------------------------------------------------------
// ckg_pkg
// Shared definitions for the activity-driven clock-gating controller:
//   - FSM state encoding (RUN, REQ, OFF, WAKE)
//   - idle / wake counter widths
//   - the fixed per-state output set and its decoder
// ---------------------------------------------------------------------------
package ckg_pkg;

  localparam int IDLE_W = 16;
  localparam int WAKE_W = 8;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    REQ  = 2'd1,
    OFF  = 2'd2,
    WAKE = 2'd3
  } ckg_state_e;

  typedef struct packed {
    logic cg_en;
    logic slp_req;
    logic rdy;
  } ckg_out_t;

  // Every state drives a fixed output set, so the outputs are a pure
  // function of the state.
  function automatic ckg_out_t ckg_decode(input ckg_state_e st);
    ckg_out_t o;
    unique case (st)
      RUN:     o = '{cg_en: 1'b1, slp_req: 1'b0, rdy: 1'b1};
      REQ:     o = '{cg_en: 1'b1, slp_req: 1'b1, rdy: 1'b1};
      OFF:     o = '{cg_en: 1'b0, slp_req: 1'b1, rdy: 1'b0};
      WAKE:    o = '{cg_en: 1'b1, slp_req: 1'b1, rdy: 1'b0};
      default: o = '{cg_en: 1'b1, slp_req: 1'b0, rdy: 1'b1};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/ckg_if.sv
// ---------------------------------------------------------------------------
// ckg_if
// Sleep-negotiation handshake between the clock-gating controller and its
// gated domain.
//   ACT     : domain -> ctrl, 1 = busy this cycle
//   SLP_ACK : domain -> ctrl, domain has quiesced
//   SLP_REQ : ctrl -> domain, sleep request
//   RDY     : ctrl -> domain, gated clock running and stable
// Modports: master = controller side, slave = gated-domain side.
// ---------------------------------------------------------------------------
interface ckg_if;

  logic ACT;
  logic SLP_ACK;
  logic SLP_REQ;
  logic RDY;

  modport master (
    input  ACT,
    input  SLP_ACK,
    output SLP_REQ,
    output RDY
  );

  modport slave (
    output ACT,
    output SLP_ACK,
    input  SLP_REQ,
    input  RDY
  );

endinterface

// File: rtl/ckg_ctrl_icg.sv
// ---------------------------------------------------------------------------
// CKICG
// Integrated clock-gate cell: latch-based, glitch-free AND gate.
//   LIB : library selector
//   E   : functional enable
//   TE  : scan test enable (forces the clock on)
//   CK  : source clock
//   Q   : gated clock
// The enable is captured by a latch that is transparent while CK is low, so
// it can only change during the low phase and Q = CK & en never glitches.
// ---------------------------------------------------------------------------
module CKICG #(
  parameter string LIB = "PSC_L40"
) (
  input  logic E,
  input  logic TE,
  input  logic CK,
  output logic Q
);

  if (LIB == "PSC_L40") begin : g_psc_l40
    logic en_l;

    // NOTE: the enable latch is intentional; always_latch states that
    // explicitly instead of leaving an incomplete always_comb to infer one.
    always_latch begin
      if (!CK) en_l <= E | TE;
    end

    assign Q = CK & en_l;
  end else begin : g_generic
    // Libraries without a dedicated model share the same behavioural cell.
    logic en_l;

    always_latch begin
      if (!CK) en_l <= E | TE;
    end

    assign Q = CK & en_l;
  end

endmodule

// File: rtl/ckg_ctrl.sv
// ---------------------------------------------------------------------------
// ckg_ctrl
// Activity-driven clock-gating controller for one gated leaf domain.
// Counts idle cycles, negotiates sleep with the domain over ckg_if, and
// drives the enable of one CKICG instance.
// Parameters:
//   LIB      : library selector passed to CKICG
//   IDLE_CYC : consecutive idle cycles before SLP_REQ (1..65535)
//   WAKE_CYC : gated-clock cycles after wake before RDY (1..255)
// Ports:
//   CK    : free-running source clock
//   RST   : synchronous, active-high reset
//   BYP   : static bypass, forces the clock on / FSM in RUN
//   TE    : scan test enable, only reaches CKICG.TE
//   bus   : handshake (ACT, SLP_ACK in; SLP_REQ, RDY out)
//   CG_EN : registered ICG enable
//   GCK   : gated clock
//   ST    : current FSM state
// ---------------------------------------------------------------------------
module ckg_ctrl
  import ckg_pkg::*;
#(
  parameter string LIB      = "PSC_L40",
  parameter int    IDLE_CYC = 16,
  parameter int    WAKE_CYC = 2
) (
  input  logic       CK,
  input  logic       RST,
  input  logic       BYP,
  input  logic       TE,
  ckg_if.master      bus,
  output logic       CG_EN,
  output logic       GCK,
  output logic [1:0] ST
);

  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYC - 1);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYC - 1);

  ckg_state_e        state_q, state_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
  ckg_out_t          out_q, out_d;

  logic wake_evt;
  assign wake_evt = bus.ACT | BYP;

  // NOTE: every combinational output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;

    unique case (state_q)
      RUN: begin
        if (wake_evt) begin
          idle_cnt_d = '0;
        end else begin
          if (idle_cnt_q != '1) idle_cnt_d = idle_cnt_q + 1'b1;
          if (idle_cnt_q == IDLE_LAST) state_d = REQ;
        end
      end
      REQ: begin
        // Activity or bypass aborts the request, even against SLP_ACK.
        if (wake_evt) begin
          state_d    = RUN;
          idle_cnt_d = '0;
        end else if (bus.SLP_ACK) begin
          state_d = OFF;
        end
      end
      OFF: begin
        if (wake_evt) begin
          state_d    = WAKE;
          wake_cnt_d = '0;
        end
      end
      WAKE: begin
        // ACT is ignored here; the clock has to settle before RUN.
        wake_cnt_d = wake_cnt_q + 1'b1;
        if (wake_cnt_q == WAKE_LAST) begin
          state_d    = RUN;
          idle_cnt_d = '0;
        end
      end
      default: begin
        state_d    = RUN;
        idle_cnt_d = '0;
        wake_cnt_d = '0;
      end
    endcase

    // Outputs are registered from the next state, so they always equal the
    // decode of the registered state without a combinational decoder on pins.
    out_d = ckg_decode(state_d);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q    <= RUN;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      out_q      <= ckg_decode(RUN);
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      out_q      <= out_d;
    end
  end

  assign CG_EN       = out_q.cg_en;
  assign bus.SLP_REQ = out_q.slp_req;
  assign bus.RDY     = out_q.rdy;
  assign ST          = state_q;

  CKICG #(
    .LIB (LIB)
  ) u_icg (
    .E  (out_q.cg_en),
    .TE (TE),
    .CK (CK),
    .Q  (GCK)
  );

endmodule

// File: doc/ckg_ctrl.md
# ckg_ctrl

Activity-driven clock-gating controller: the control end of the integrated clock-gate (ICG) cell. It watches an activity strobe from a gated sub-domain, negotiates sleep with that domain through a request/acknowledge handshake, and drives the enable of one CKICG instance to stop and restart the domain clock. It sits at the boundary between the always-on CK tree and one gated leaf domain; one instance is used per gated domain.

## Interface

- LIB, "PSC_L40": library selector, passed unchanged to the CKICG sub-instance.
- IDLE_CYC, 16: consecutive idle cycles before sleep is requested; legal range 1..65535.
- WAKE_CYC, 2: cycles the gated clock runs after wake before RDY rises; legal range 1..255.
- CK  in  1  free-running source clock.
- RST  in  1  reset: synchronous, active-high.
- ACT  in  1  activity strobe from the gated domain or its requesters; 1 = busy this cycle.
- BYP  in  1  static bypass; 1 forces the clock on and holds the FSM in RUN.
- TE  in  1  scan test enable; forwarded to CKICG.TE only, so it does not affect the FSM.
- SLP_ACK  in  1  gated domain has quiesced; sampled only in REQ.
- SLP_REQ  out  1  sleep request to the gated domain.
- RDY  out  1  gated clock running and stable.
- CG_EN  out  1  registered ICG enable (observation).
- GCK  out  1  gated clock (CKICG.Q).
- ST  out  2  current FSM state (observation).

## Operation

- There are 4 states, each with a fixed output set:
  - RUN=0: CG_EN=1, SLP_REQ=0, RDY=1.
  - REQ=1: CG_EN=1, SLP_REQ=1, RDY=1.
  - OFF=2: CG_EN=0, SLP_REQ=1, RDY=0.
  - WAKE=3: CG_EN=1, SLP_REQ=1, RDY=0.
- All outputs except GCK are registered, decoded from the registered state.
- RUN:
  - The idle counter clears on ACT=1 or BYP=1 and otherwise increments, saturating.
  - When ACT=0, BYP=0 and count==IDLE_CYC-1, go to REQ.
- REQ:
  - ACT=1 goes to RUN and clears the counter. Abort has priority over SLP_ACK in the same cycle.
  - Otherwise SLP_ACK=1 goes to OFF.
  - Otherwise stay in REQ. There is no timeout.
- OFF: ACT=1 or BYP=1 goes to WAKE and loads the wake counter with 0.
- WAKE:
  - The wake counter increments each cycle.
  - When count==WAKE_CYC-1, go to RUN and clear the idle counter.
  - ACT is ignored in WAKE.
- BYP=1 in REQ forces RUN; in RUN it holds RUN.
- Counter widths: idle is 16 bits and wake is 8 bits. Comparisons are unsigned.
- Reset (synchronous, takes effect at the next CK edge from any state, including OFF):
  - state=RUN, both counters=0.
  - CG_EN=1, SLP_REQ=0, RDY=1.
  - The clock restarts immediately and no handshake is issued.

## Timing

- The ICG latches CG_EN while CK is low. When CG_EN changes at rising edge N, the GCK level at rising edge N+1 reflects the new value.
- Gate-off sequence:
  - SLP_ACK is sampled high at edge N and the state becomes OFF at N.
  - GCK still pulses at edge N.
  - No GCK pulse occurs from edge N+1 onward.
- Wake sequence:
  - ACT is sampled high at edge N in OFF and the state becomes WAKE at N.
  - GCK resumes at edge N+1.
  - RUN is entered and RDY rises and SLP_REQ falls at edge N+WAKE_CYC.
- Idle-to-request sequence:
  - The last ACT=1 is sampled at edge N.
  - SLP_REQ rises at edge N+IDLE_CYC.
- The gated domain holds SLP_ACK until SLP_REQ falls. SLP_ACK outside REQ is ignored.
- GCK is glitch-free under any ACT/BYP/RST sequence, because the ICG latch filters the enable.

## Structure

- Shared package ckg_pkg holds:
  - the state encoding constants (RUN, REQ, OFF, WAKE);
  - the counter widths (16 and 8).
- Exactly one sub-module instance: CKICG (LIB passed through), with E=CG_EN, TE=TE, CK=CK, Q=GCK.
- Single always block for the state register and counters; next-state logic is combinational.

## Test plan

- Reset and idle: RST for 2 cycles, then ACT=0 with IDLE_CYC=16 → SLP_REQ rises exactly 16 edges after reset release. CG_EN=1 and RDY=1 throughout.
- Full sleep/wake: with WAKE_CYC=2, SLP_ACK=1 in REQ → OFF, and GCK has no pulses for 10 cycles. ACT pulse → GCK resumes at the next edge, and RDY=1 and SLP_REQ=0 two edges after the ACT sample.
- Abort: ACT=1 and SLP_ACK=1 sampled at the same edge in REQ → state RUN, SLP_REQ=0, idle counter=0, GCK never stops.
- Bypass: BYP=1 held with ACT=0 for 100 cycles → ST stays RUN and SLP_REQ stays 0. BYP=1 in OFF → WAKE, then RUN.
- Reset mid-sleep: RST=1 while in OFF → at the next edge ST=RUN, CG_EN=1, SLP_REQ=0, RDY=1, and GCK toggles on the following edge.
- Scan: TE=1 while in OFF → GCK toggles every cycle, while ST stays OFF and SLP_REQ stays 1.
